// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC layer control blocks.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_WAIT_OBUF,
        ST_CIM_ACK,
        ST_CIM_WAIT,
        ST_FUNC
    } fc_pp_state_t;

    // Address width for an n-word vector; never narrower than one bit.
    function automatic int fc_addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_bank_tracker.sv
// Input-buffer bank occupancy: full flags, write/read pointers, ready and sticky overflow.
module fc_bank_tracker #(
    parameter int DOUBLE_BUF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic release_i,
    output logic ready_o,
    output logic wr_bank_o,
    output logic rd_bank_o,
    output logic rd_full_o,
    output logic overflow_o
);

    logic [1:0] full_q, full_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       ovf_q, ovf_d;
    logic       accept;

    assign accept = start_i & ~full_q[wr_ptr_q];

    // accept targets an empty bank and release a full one, so they never hit the same flag
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q | (start_i & full_q[wr_ptr_q]);
        if (accept) begin
            full_d[wr_ptr_q] = 1'b1;
            if (DOUBLE_BUF != 0) wr_ptr_d = ~wr_ptr_q;
        end
        if (release_i) begin
            full_d[rd_ptr_q] = 1'b0;
            if (DOUBLE_BUF != 0) rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready_o    = ~full_q[wr_ptr_q];
    assign wr_bank_o  = wr_ptr_q;
    assign rd_bank_o  = rd_ptr_q;
    // Lets IDLE leave the cycle right after a fill lands on the read bank.
    assign rd_full_o  = full_q[rd_ptr_q] | (accept & (wr_ptr_q == rd_ptr_q));
    assign overflow_o = ovf_q;

endmodule

// File: rtl/fc_pp_ctrl.sv
// Ping-pong FC layer controller: streams an ibuf bank to the CIM tiles, then
// sequences CIM compute and the obuf handoff to the function unit.
module fc_pp_ctrl
    import fc_pkg::*;
#(
    parameter int DOUBLE_BUF   = 1,
    parameter int NUM_ADDR     = 32,
    parameter int ADDR_W       = fc_addr_w(NUM_ADDR),
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_ready,
    output logic              o_wr_bank,
    output logic              o_rd_bank,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_cim_we,
    output logic              o_cim_start,
    input  logic              i_cim_ready,
    output logic              o_func_start,
    input  logic              i_func_ready,
    output logic              o_overflow
);

    localparam int CNT_W = 3;

    fc_pp_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              release_w;
    logic              rd_full;
    logic              stream_vld;

    fc_bank_tracker #(.DOUBLE_BUF(DOUBLE_BUF)) u_banks (
        .clk        (clk),
        .rst        (rst),
        .start_i    (i_start),
        .release_i  (release_w),
        .ready_o    (o_ready),
        .wr_bank_o  (o_wr_bank),
        .rd_bank_o  (o_rd_bank),
        .rd_full_o  (rd_full),
        .overflow_o (o_overflow)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        release_w    = 1'b0;
        o_cim_start  = 1'b0;
        o_func_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_full) begin
                    state_d = ST_STREAM;
                    addr_d  = '0;
                end
            end
            ST_STREAM: begin
                if (addr_q == ADDR_W'(NUM_ADDR - 1)) begin
                    addr_d = '0;
                    cnt_d  = '0;
                    if (READ_LATENCY == 0) begin
                        release_w = 1'b1;
                        state_d   = ST_WAIT_OBUF;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            // Last DRAIN cycle is the one carrying the final o_cim_we.
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                    release_w = 1'b1;
                    state_d   = ST_WAIT_OBUF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_OBUF: begin
                if (i_func_ready && i_cim_ready) begin
                    o_cim_start = 1'b1;
                    state_d     = ST_CIM_ACK;
                end
            end
            ST_CIM_ACK: state_d = ST_CIM_WAIT;
            ST_CIM_WAIT: begin
                if (i_cim_ready) state_d = ST_FUNC;
            end
            ST_FUNC: begin
                if (i_func_ready) begin
                    o_func_start = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_addr     = addr_q;
    assign stream_vld = (state_q == ST_STREAM);

    // o_cim_we tracks ibuf read data, i.e. the stream flag delayed by the read latency.
    generate
        if (READ_LATENCY == 0) begin : g_we_comb
            assign o_cim_we = stream_vld;
        end else begin : g_we_pipe
            logic [READ_LATENCY:1] vld_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[1] <= stream_vld;
                    for (int k = 2; k <= READ_LATENCY; k++) vld_q[k] <= vld_q[k-1];
                end
            end
            assign o_cim_we = vld_q[READ_LATENCY];
        end
    endgenerate

endmodule

// File: tb/tb_fc_pp_ctrl.sv
// Directed bench: a double-buffered instance (NUM_ADDR=4, RL=2) and a
// single-buffered instance (NUM_ADDR=4, RL=1) share clock and reset.
module tb_fc_pp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // double-buffered instance
    logic       start = 1'b0, cim_rdy = 1'b1, func_rdy = 1'b1;
    logic       ready, wr_bank, rd_bank, we, cs, fs, ovf;
    logic [1:0] addr;

    // single-buffered instance
    logic       s_start = 1'b0, s_cim_rdy = 1'b1, s_func_rdy = 1'b1;
    logic       s_ready, s_wr_bank, s_rd_bank, s_we, s_cs, s_fs, s_ovf;
    logic [1:0] s_addr;

    fc_pp_ctrl #(.DOUBLE_BUF(1), .NUM_ADDR(4), .ADDR_W(2), .READ_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .o_ready(ready), .o_wr_bank(wr_bank),
        .o_rd_bank(rd_bank), .o_addr(addr), .o_cim_we(we), .o_cim_start(cs),
        .i_cim_ready(cim_rdy), .o_func_start(fs), .i_func_ready(func_rdy), .o_overflow(ovf)
    );

    fc_pp_ctrl #(.DOUBLE_BUF(0), .NUM_ADDR(4), .ADDR_W(2), .READ_LATENCY(1)) u_sb (
        .clk(clk), .rst(rst), .i_start(s_start), .o_ready(s_ready), .o_wr_bank(s_wr_bank),
        .o_rd_bank(s_rd_bank), .o_addr(s_addr), .o_cim_we(s_we), .o_cim_start(s_cs),
        .i_cim_ready(s_cim_rdy), .o_func_start(s_fs), .i_func_ready(s_func_rdy), .o_overflow(s_ovf)
    );

    task automatic do_reset();
        start = 1'b0; cim_rdy = 1'b1; func_rdy = 1'b1;
        s_start = 1'b0; s_cim_rdy = 1'b1; s_func_rdy = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        exp_v = 9'b1_0000_0000;
        rst = 1'b1;
        #2;
        checks++;
        if ({ready, wr_bank, rd_bank, addr, we, cs, fs, ovf} !== exp_v) begin
            errors++;
            $display("FAIL reset_dbuf: got %b want %b", {ready, wr_bank, rd_bank, addr, we, cs, fs, ovf}, exp_v);
        end
        checks++;
        if ({s_ready, s_wr_bank, s_rd_bank, s_addr, s_we, s_cs, s_fs, s_ovf} !== exp_v) begin
            errors++;
            $display("FAIL reset_sbuf: got %b want %b", {s_ready, s_wr_bank, s_rd_bank, s_addr, s_we, s_cs, s_fs, s_ovf}, exp_v);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({ready, wr_bank, rd_bank, addr, we, cs, fs, ovf} !== exp_v) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", {ready, wr_bank, rd_bank, addr, we, cs, fs, ovf}, exp_v);
        end
    endtask

    task automatic test_single();
        logic [4:0] exp_v;
        logic [1:0] ea;
        do_reset();
        for (int cyc = 0; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0);
            @(negedge clk);
            ea    = (cyc >= 1 && cyc <= 4) ? 2'(cyc - 1) : 2'd0;
            exp_v = {ea, (cyc >= 3 && cyc <= 6), (cyc == 7), (cyc == 10)};
            checks++;
            if ({addr, we, cs, fs} !== exp_v) begin
                errors++;
                $display("FAIL single_trace cyc=%0d: addr/we/cs/fs got %b want %b", cyc, {addr, we, cs, fs}, exp_v);
            end
            if (cyc == 1) begin
                checks++;
                if ({ready, wr_bank} !== 2'b11) begin
                    errors++;
                    $display("FAIL single_ptr: ready/wr_bank got %b want 11", {ready, wr_bank});
                end
            end
        end
    endtask

    task automatic test_ping_pong();
        int we_cnt = 0;
        do_reset();
        for (int cyc = 0; cyc <= 17; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0 || cyc == 3);
            @(negedge clk);
            if (we) we_cnt++;
            if (cyc == 1) begin
                checks++;
                if ({ready, wr_bank, rd_bank, addr} !== 5'b11000) begin
                    errors++;
                    $display("FAIL pp_first: ready/wr/rd/addr got %b want 11000", {ready, wr_bank, rd_bank, addr});
                end
            end
            if (cyc == 4) begin
                checks++;
                if ({wr_bank, rd_bank} !== 2'b00) begin
                    errors++;
                    $display("FAIL pp_second: wr/rd got %b want 00", {wr_bank, rd_bank});
                end
            end
            if (cyc >= 12 && cyc <= 15) begin
                checks++;
                if ({rd_bank, addr} !== {1'b1, 2'(cyc - 12)}) begin
                    errors++;
                    $display("FAIL pp_bank1 cyc=%0d: rd/addr got %b want %b", cyc, {rd_bank, addr}, {1'b1, 2'(cyc - 12)});
                end
            end
        end
        checks++;
        if (we_cnt != 8 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL pp_total: we_cycles=%0d ovf=%b want 8 and 0", we_cnt, ovf);
        end
    endtask

    task automatic test_backpressure();
        int we_cnt = 0;
        int cs_cnt = 0;
        do_reset();
        for (int cyc = 0; cyc <= 29; cyc++) begin
            @(posedge clk); #1;
            start    = (cyc == 0 || cyc == 3);
            func_rdy = !(cyc >= 11 && cyc <= 24);
            @(negedge clk);
            if (cyc >= 11 && cyc <= 24) begin
                if (we) we_cnt++;
                if (cs) cs_cnt++;
            end
            if (cyc == 10) begin
                checks++;
                if (fs !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_first_func: fs got %b want 1", fs);
                end
            end
            if (cyc == 25) begin
                checks++;
                if (cs !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_cim_release: cs got %b want 1", cs);
                end
            end
            if (cyc == 28) begin
                checks++;
                if (fs !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_second_func: fs got %b want 1", fs);
                end
            end
        end
        checks++;
        if (we_cnt != 4 || cs_cnt != 0) begin
            errors++;
            $display("FAIL bp_held: we_cycles=%0d cs_cycles=%0d want 4 and 0", we_cnt, cs_cnt);
        end
    endtask

    task automatic test_cim_handshake();
        int fs_cnt = 0;
        do_reset();
        for (int cyc = 0; cyc <= 22; cyc++) begin
            @(posedge clk); #1;
            start   = (cyc == 0);
            cim_rdy = !(cyc >= 9 && cyc <= 18);
            @(negedge clk);
            if (cyc >= 8 && cyc <= 19 && fs) fs_cnt++;
            if (cyc == 7) begin
                checks++;
                if (cs !== 1'b1) begin
                    errors++;
                    $display("FAIL cim_start: cs got %b want 1", cs);
                end
            end
            if (cyc == 20) begin
                checks++;
                if (fs !== 1'b1) begin
                    errors++;
                    $display("FAIL cim_func_after_rise: fs got %b want 1", fs);
                end
            end
        end
        checks++;
        if (fs_cnt != 0) begin
            errors++;
            $display("FAIL cim_early_func: fs cycles got %0d want 0", fs_cnt);
        end
    endtask

    task automatic test_single_buf();
        int  we_cnt = 0;
        logic bank_nz = 1'b0;
        do_reset();
        for (int cyc = 0; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            s_start = (cyc == 0 || cyc == 2);
            @(negedge clk);
            if (s_we) we_cnt++;
            if (s_wr_bank || s_rd_bank) bank_nz = 1'b1;
            if (cyc == 3) begin
                checks++;
                if (s_ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_overflow: ovf got %b want 1", s_ovf);
                end
            end
            if (cyc == 5 || cyc == 6) begin
                checks++;
                if (s_ready !== (cyc == 6)) begin
                    errors++;
                    $display("FAIL sb_ready cyc=%0d: got %b want %b", cyc, s_ready, (cyc == 6));
                end
            end
        end
        checks++;
        if (we_cnt != 4 || bank_nz || s_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sb_total: we_cycles=%0d bank_nz=%b ovf=%b want 4,0,1", we_cnt, bank_nz, s_ovf);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic late_we = 1'b0;
        do_reset();
        for (int cyc = 0; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            s_start = (cyc == 0 || cyc == 2);
            @(negedge clk);
        end
        checks++;
        if ({s_addr, s_we, s_ovf} !== 4'b1011) begin
            errors++;
            $display("FAIL rst_pre: addr/we/ovf got %b want 1011", {s_addr, s_we, s_ovf});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, s_wr_bank, s_rd_bank, s_addr, s_we, s_cs, s_fs, s_ovf} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL rst_async: got %b want 100000000", {s_ready, s_wr_bank, s_rd_bank, s_addr, s_we, s_cs, s_fs, s_ovf});
        end
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (s_we || s_addr != 2'd0) late_we = 1'b1;
        end
        checks++;
        if (late_we || s_ready !== 1'b1 || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: late_activity=%b ready=%b ovf=%b want 0,1,0", late_we, s_ready, s_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ping_pong();
        test_backpressure();
        test_cim_handshake();
        test_single_buf();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_pp_ctrl.md
# fc_pp_ctrl

Double-buffered controller for one fully-connected layer. It is the next generation of the FC layer control path and sits between the previous layer's writes into the input buffer and the CIM tiles. While the CIM tiles and the output-side function unit work on one input vector, the previous layer can fill the other bank. The block streams a full bank into the CIM tiles, compensating for the ibuf's parametrised read latency. It then sequences CIM compute and the handoff to the output-side function unit, and it blocks a new compute until the output buffer has been consumed.

## Interface
- DOUBLE_BUF, 1, 1 = two ibuf banks (ping-pong); 0 = one bank, bank index outputs tied 0
- NUM_ADDR, 32, ibuf words per input vector (≥1)
- ADDR_W, max(1,$clog2(NUM_ADDR)), address width
- READ_LATENCY, 1, ibuf read latency in cycles (0..4)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  pulse: previous layer finished filling bank o_wr_bank
- o_ready  out  1  bank o_wr_bank is free to be written
- o_wr_bank  out  1  bank the previous layer writes
- o_rd_bank  out  1  bank being streamed to CIM
- o_addr  out  ADDR_W  ibuf read address
- o_cim_we  out  1  o_addr data (delayed READ_LATENCY) valid on CIM bus
- o_cim_start  out  1  one-cycle compute start pulse
- i_cim_ready  in  1  CIM tiles idle
- o_func_start  out  1  one-cycle pulse: function unit may drain obuf
- i_func_ready  in  1  function unit idle / obuf consumed
- o_overflow  out  1  sticky: i_start received while o_ready=0

## Operation
- Bank tracking: full[1:0], wr_ptr, rd_ptr.
  - i_start with o_ready=1 sets full[wr_ptr] and toggles wr_ptr (DOUBLE_BUF=1 only).
  - i_start with o_ready=0 is ignored and sets o_overflow.
  - o_ready = !full[wr_ptr].
- FSM states: IDLE, STREAM, DRAIN, WAIT_OBUF, CIM_ACK, CIM_WAIT, FUNC.
- IDLE: if full[rd_ptr] -> STREAM, with o_addr=0.
- STREAM: one read per cycle, addr 0..NUM_ADDR-1. After the last address -> DRAIN, or directly to the release step if READ_LATENCY=0.
- DRAIN: wait READ_LATENCY cycles, until the last o_cim_we is issued.
- Bank release: on leaving DRAIN, clear full[rd_ptr] and toggle rd_ptr (DOUBLE_BUF=1). Then -> WAIT_OBUF.
- WAIT_OBUF: when i_func_ready && i_cim_ready, pulse o_cim_start -> CIM_ACK.
- CIM_ACK: one cycle in which i_cim_ready is ignored -> CIM_WAIT.
- CIM_WAIT: when i_cim_ready=1 -> FUNC.
- FUNC: when i_func_ready=1, pulse o_func_start -> IDLE.
- Overlap: after FUNC, streaming of the next bank proceeds while the function unit drains obuf. WAIT_OBUF is what prevents overwriting obuf.
- o_cim_we: a READ_LATENCY-deep shift of the STREAM-valid flag. With READ_LATENCY=0 it is combinational with STREAM.
- Simultaneous events:
  - i_start in the cycle a bank is released: evaluated against pre-release state. With DOUBLE_BUF=0 this is an overflow.
  - i_start on an empty bank while the FSM is in IDLE: STREAM is entered the next cycle.

## Timing
- Reset values:
  - o_ready=1, all other outputs 0, o_addr=0.
  - full=0, wr_ptr=rd_ptr=0, state IDLE.
  - Delay line cleared; o_overflow cleared only by rst.
- Reset mid-operation: immediate return to reset values. No pulse completes.
- Latencies:
  - i_start to first o_addr change: 1 cycle (IDLE→STREAM) plus 1 cycle.
  - First o_cim_we: READ_LATENCY cycles after first STREAM cycle.
  - o_cim_we is high for exactly NUM_ADDR consecutive cycles.
- o_cim_start and o_func_start are exactly one cycle wide and never asserted together.
- o_ready reflects i_start one cycle later (registered full flags).

## Structure
- Package fc_pkg: FSM state enum fc_pp_state_t; localparam helper for ADDR_W. Shared with other FC control blocks.
- Sub-module fc_bank_tracker: full flags, wr/rd pointers, o_ready, overflow. Parameterised by DOUBLE_BUF.
- Remaining logic (FSM, address counter, we delay line) lives in fc_pp_ctrl.

## Test plan
- Single vector, NUM_ADDR=4, READ_LATENCY=2, func and CIM always ready:
  - o_addr goes 0,1,2,3.
  - o_cim_we is high for 4 cycles, starting 2 cycles after addr 0.
  - Then one o_cim_start, then one o_func_start.
- Ping-pong:
  - Two i_start pulses 3 cycles apart: o_wr_bank 0→1→0, o_ready stays 1 after the first pulse.
  - Banks are streamed in order 0 then 1; no overflow.
- Obuf backpressure: hold i_func_ready=0 after the first o_func_start.
  - The second bank streams fully.
  - o_cim_start is withheld until i_func_ready=1, then fires on the next edge.
- DOUBLE_BUF=0:
  - i_start during STREAM sets o_overflow=1; the ignored vector is never streamed.
  - o_ready returns to 1 one cycle after DRAIN exits.
- CIM handshake:
  - i_cim_ready held high through the cycle after o_cim_start: ignored (CIM_ACK).
  - Then drop it for 10 cycles and raise it: o_func_start fires only after the rise.
- Reset: assert rst mid-STREAM at o_addr=2, READ_LATENCY=1.
  - All outputs return to reset values asynchronously; no further o_cim_we.
  - o_ready=1 and o_overflow=0.
